// File: rtl/seq_deser.sv
// Serial-to-parallel receiver: hunts for a framing header, then assembles a payload word MSB first.
// Optional even-parity trailer bit is enabled by defining PARITY_EN.
module seq_deser #(
    parameter int                HDR_W  = 5,
    parameter logic [HDR_W-1:0]  HDR    = 5'b10110,
    parameter int                DATA_W = 16,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seq_bit,
    input  logic              bit_vld,
    output logic [DATA_W-1:0] data,
    output logic              data_vld,
    output logic              par_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [2:0]        state
);

    localparam int FILL_W = $clog2(HDR_W + 1);
    localparam int BCNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_RECV = 3'd1,
        ST_PAR  = 3'd2
    } state_t;

`ifdef PARITY_EN
    // True when payload plus parity bit carries an even number of ones.
    function automatic logic even_par_ok(input logic [DATA_W-1:0] w, input logic p);
        return ~((^w) ^ p);
    endfunction
`endif

    state_t              state_r,     state_s;
    logic [HDR_W-1:0]    hdr_r,       hdr_s;
    logic [FILL_W-1:0]   fill_r,      fill_s;
    logic [BCNT_W-1:0]   bcnt_r,      bcnt_s;
    logic [DATA_W-1:0]   word_r,      word_s;
    logic [DATA_W-1:0]   data_r,      data_s;
    logic                data_vld_r,  data_vld_s;
    logic                par_err_r,   par_err_s;
    logic [CNT_W-1:0]    cnt_r,       cnt_s;
    logic [HDR_W-1:0]    hdr_cand_s;

    // Header window as it would look with the current bit appended.
    assign hdr_cand_s = {hdr_r[HDR_W-2:0], seq_bit};

    // Next-state, datapath and strobe computation.
    always_comb begin
        state_s    = state_r;
        hdr_s      = hdr_r;
        fill_s     = fill_r;
        bcnt_s     = bcnt_r;
        word_s     = word_r;
        data_s     = data_r;
        data_vld_s = 1'b0;
        par_err_s  = 1'b0;
        cnt_s      = cnt_r;
        if (bit_vld) begin
            case (state_r)
                ST_HUNT: begin
                    if ((fill_r >= FILL_W'(HDR_W - 1)) && (hdr_cand_s == HDR)) begin
                        // Window clears here so payload bits never feed the next hunt.
                        state_s = ST_RECV;
                        bcnt_s  = '0;
                        hdr_s   = '0;
                        fill_s  = '0;
                    end else begin
                        hdr_s = hdr_cand_s;
                        if (fill_r < FILL_W'(HDR_W)) begin
                            fill_s = fill_r + FILL_W'(1);
                        end else begin
                            fill_s = fill_r;
                        end
                    end
                end
                ST_RECV: begin
                    word_s = {word_r[DATA_W-2:0], seq_bit};
                    if (bcnt_r == BCNT_W'(DATA_W - 1)) begin
`ifdef PARITY_EN
                        state_s = ST_PAR;
`else
                        data_s     = word_s;
                        data_vld_s = 1'b1;
                        cnt_s      = cnt_r + CNT_W'(1);
                        state_s    = ST_HUNT;
`endif
                    end else begin
                        bcnt_s = bcnt_r + BCNT_W'(1);
                    end
                end
`ifdef PARITY_EN
                ST_PAR: begin
                    state_s = ST_HUNT;
                    if (even_par_ok(word_r, seq_bit)) begin
                        data_s     = word_r;
                        data_vld_s = 1'b1;
                        cnt_s      = cnt_r + CNT_W'(1);
                    end else begin
                        par_err_s = 1'b1;
                    end
                end
`endif
                default: begin
                    state_s = ST_HUNT;
                    hdr_s   = '0;
                    fill_s  = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            hdr_r      <= '0;
            fill_r     <= '0;
            bcnt_r     <= '0;
            word_r     <= '0;
            data_r     <= '0;
            data_vld_r <= 1'b0;
            par_err_r  <= 1'b0;
            cnt_r      <= '0;
        end else begin
            state_r    <= state_s;
            hdr_r      <= hdr_s;
            fill_r     <= fill_s;
            bcnt_r     <= bcnt_s;
            word_r     <= word_s;
            data_r     <= data_s;
            data_vld_r <= data_vld_s;
            par_err_r  <= par_err_s;
            cnt_r      <= cnt_s;
        end
    end

    assign data      = data_r;
    assign data_vld  = data_vld_r;
    assign par_err   = par_err_r;
    assign frame_cnt = cnt_r;
    assign state     = state_r;

endmodule

// File: tb/tb_seq_deser.sv
// Self-checking bench for seq_deser: directed frames plus randomized streams against a queue-based model.
module tb_seq_deser;
    localparam int          HDR_W  = 5;
    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 8;
    localparam logic [4:0]  HDR    = 5'b10110;
`ifdef PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              seq_bit;
    logic              bit_vld;
    logic [DATA_W-1:0] data;
    logic              data_vld;
    logic              par_err;
    logic [CNT_W-1:0]  frame_cnt;
    logic [2:0]        state;

    seq_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seq_bit   (seq_bit),
        .bit_vld   (bit_vld),
        .data      (data),
        .data_vld  (data_vld),
        .par_err   (par_err),
        .frame_cnt (frame_cnt),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobes      = 0;

    // Reference model: mode 0 hunting, 1 collecting payload, 2 awaiting parity.
    int          m_mode;
    bit          hist[$];
    bit          pay[$];
    logic [15:0] m_data;
    bit          m_vld;
    bit          m_perr;
    int          m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; hist.delete(); pay.delete();
        m_data = 16'h0; m_vld = 1'b0; m_perr = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_accept();
        int w = 0;
        foreach (pay[i]) w = w * 2 + int'(pay[i]);
        m_data = w[15:0];
        m_vld  = 1'b1;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_mode = 0;
        pay.delete();
    endfunction

    function automatic void model_bit(input bit b, input bit v);
        int val;
        int ones;
        m_vld  = 1'b0;
        m_perr = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                hist.push_back(b);
                if (hist.size() > HDR_W) void'(hist.pop_front());
                if (hist.size() == HDR_W) begin
                    val = 0;
                    foreach (hist[i]) val = val * 2 + int'(hist[i]);
                    if (val == int'(HDR)) begin
                        m_mode = 1; hist.delete(); pay.delete();
                    end
                end
            end else if (m_mode == 1) begin
                pay.push_back(b);
                if (pay.size() == DATA_W) begin
                    if (PAR_ON) m_mode = 2;
                    else model_accept();
                end
            end else begin
                ones = int'(b);
                foreach (pay[i]) ones += int'(pay[i]);
                if (ones % 2 == 0) model_accept();
                else begin
                    m_perr = 1'b1; m_mode = 0; pay.delete();
                end
            end
        end
    endfunction

    task automatic check_all();
        check_eq("data", 32'(data), 32'(m_data));
        check_eq("data_vld", 32'(data_vld), 32'(m_vld));
        check_eq("par_err", 32'(par_err), 32'(m_perr));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check_eq("state", 32'(state), 32'(m_mode));
    endtask

    task automatic step(input bit b, input bit v);
        seq_bit = b;
        bit_vld = v;
        @(posedge clk);
        model_bit(b, v);
        #1;
        check_all();
        if (data_vld) strobes++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] w, input bit bad_par, input int gap);
        logic [4:0] h;
        bit p;
        h = HDR;
        for (int i = HDR_W - 1; i >= 0; i--) begin
            repeat (gap) step(1'b0, 1'b0);
            step(h[i], 1'b1);
        end
        for (int i = DATA_W - 1; i >= 0; i--) begin
            repeat (gap) step(1'b0, 1'b0);
            step(w[i], 1'b1);
        end
        if (PAR_ON) begin
            p = (^w) ^ bad_par;
            repeat (gap) step(1'b0, 1'b0);
            step(p, 1'b1);
        end
    endtask

    initial begin
        logic [7:0]  noise;
        logic [15:0] w;
        int          s0;
        rst_n   = 1'b0;
        seq_bit = 1'b0;
        bit_vld = 1'b0;
        model_reset();
        #12;
        do_reset();

        // Test 1: continuous frame, strobe right after the final bit edge.
        send_frame(16'h0D95, 1'b0, 0);
        check_eq("t1_vld", 32'(data_vld), 32'd1);
        check_eq("t1_data", 32'(data), 32'h0D95);
        check_eq("t1_cnt", 32'(frame_cnt), 32'd1);
        step(1'b0, 1'b0);
        check_eq("t1_vld_off", 32'(data_vld), 32'd0);
        check_eq("t1_state", 32'(state), 32'd0);

        // Test 2: noise with a partial header, then a real frame.
        noise = 8'b0000_1011;
        s0 = strobes;
        for (int i = 7; i >= 0; i--) step(noise[i], 1'b1);
        check_eq("t2_no_early", 32'(strobes - s0), 32'd0);
        send_frame(16'hA5A5, 1'b0, 0);
        check_eq("t2_data", 32'(data), 32'hA5A5);
        check_eq("t2_strobes", 32'(strobes - s0), 32'd1);

        // Test 3: idle cycle before every bit.
        send_frame(16'h0D95, 1'b0, 1);
        check_eq("t3_vld", 32'(data_vld), 32'd1);
        check_eq("t3_data", 32'(data), 32'h0D95);
        check_eq("t3_cnt", 32'(frame_cnt), 32'd3);

        // Test 4: reset after 10 payload bits, then full frame.
        w = 16'h1234;
        noise = 8'b0;
        for (int i = HDR_W - 1; i >= 0; i--) step(HDR[i], 1'b1);
        for (int i = DATA_W - 1; i >= DATA_W - 10; i--) step(w[i], 1'b1);
        do_reset();
        check_eq("t4_data_rst", 32'(data), 32'd0);
        check_eq("t4_cnt_rst", 32'(frame_cnt), 32'd0);
        send_frame(16'h1234, 1'b0, 0);
        check_eq("t4_data", 32'(data), 32'h1234);
        check_eq("t4_cnt", 32'(frame_cnt), 32'd1);

        // Test 5: 256 back-to-back frames wrap the counter.
        do_reset();
        s0 = strobes;
        for (int i = 0; i < 256; i++) send_frame(16'($urandom), 1'b0, 0);
        check_eq("t5_strobes", 32'(strobes - s0), 32'd256);
        check_eq("t5_cnt_wrap", 32'(frame_cnt), 32'd0);

`ifdef PARITY_EN
        // Test 6: good parity, bad parity, then recovery.
        do_reset();
        send_frame(16'h0D95, 1'b0, 0);
        check_eq("t6_vld", 32'(data_vld), 32'd1);
        send_frame(16'h0D95, 1'b1, 0);
        check_eq("t6_perr", 32'(par_err), 32'd1);
        check_eq("t6_vld_bad", 32'(data_vld), 32'd0);
        check_eq("t6_cnt", 32'(frame_cnt), 32'd1);
        step(1'b0, 1'b0);
        check_eq("t6_perr_off", 32'(par_err), 32'd0);
        send_frame(16'h1234, 1'b0, 0);
        check_eq("t6_next", 32'(data), 32'h1234);
`endif

        // Randomized mix of noise, gaps and embedded frames.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                send_frame(16'($urandom), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
            else
                step(1'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
